// File: rtl/lowf_fir_mac.sv
// rtl/lowf_fir_mac.sv - low-band FIR multiply-accumulate, one Q15 filtered sample per window
module lowf_fir_mac #(
    parameter int TAPS   = 1021,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 42
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [15:0]       smpl_in,
    input  logic                     sequencing,
    output logic [ADDR_W-1:0]        coeff_addr,
    input  logic signed [15:0]       coeff_data,
    output logic signed [15:0]       smpl_out,
    output logic                     smpl_vld,
    output logic                     tap_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;

    localparam logic [ADDR_W-1:0]          TAP_MAX = ADDR_W'(TAPS);
    localparam int                          SH_W    = ACC_W - 15;
    localparam logic signed [SH_W-1:0]      SAT_HI  = SH_W'(32767);
    localparam logic signed [SH_W-1:0]      SAT_LO  = SH_W'(-32768);

    state_t                    state, state_nxt;
    logic [ADDR_W-1:0]         tap_cnt;
    logic signed [15:0]        s_d;
    logic                      s_vld;
    logic signed [31:0]        prod;
    logic                      p_vld;
    logic signed [ACC_W-1:0]   acc;
    logic signed [SH_W-1:0]    acc_sh;
    logic signed [15:0]        sat_val;
    logic                      accept;
    logic                      excess;
    logic                      stray;

    // The tap counter doubles as the ROM address so coefficient k lines up with sample k
    // one cycle later, when the sample has moved into s_d.
    assign coeff_addr = tap_cnt;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        excess    = 1'b0;
        stray     = 1'b0;
        case (state)
            IDLE: begin
                if (sequencing) begin
                    accept    = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (sequencing) begin
                    if (tap_cnt < TAP_MAX) accept = 1'b1;
                    else                   excess = 1'b1;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                stray     = sequencing;
                state_nxt = OUTPUT;
            end
            OUTPUT: begin
                stray     = sequencing;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Dropping the low 15 bits is an arithmetic shift that floors toward minus infinity.
    always_comb begin
        acc_sh = acc[ACC_W-1:15];
        if (acc_sh > SAT_HI)      sat_val = 16'sh7FFF;
        else if (acc_sh < SAT_LO) sat_val = -16'sh8000;
        else                      sat_val = acc_sh[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tap_cnt  <= '0;
            s_d      <= '0;
            s_vld    <= 1'b0;
            prod     <= '0;
            p_vld    <= 1'b0;
            acc      <= '0;
            smpl_out <= '0;
            smpl_vld <= 1'b0;
            tap_ovf  <= 1'b0;
        end else begin
            state <= state_nxt;

            s_vld <= accept;
            if (accept) s_d <= smpl_in;

            if (state == OUTPUT) tap_cnt <= '0;
            else if (accept)     tap_cnt <= tap_cnt + 1'b1;

            prod  <= s_d * coeff_data;
            p_vld <= s_vld;

            if (state == OUTPUT) acc <= '0;
            else if (p_vld)      acc <= acc + {{(ACC_W-32){prod[31]}}, prod};

            smpl_vld <= (state == OUTPUT);
            if (state == OUTPUT) smpl_out <= sat_val;

            if (excess || stray) tap_ovf <= 1'b1;
        end
    end

endmodule
